sd_init_sequencer: RTL and testbench
====================================

SD_INIT_SEQUENCER -- requirements
Module: sd_init_sequencer

Interface
REQ-001 SHALL have parameter DUMMY_BYTES, default 10: number of 0xFF bytes sent with SPI_CS high before CMD0 (at least 74 clocks).
REQ-002 SHALL have parameter R1_POLL_MAX, default 8: maximum 0xFF polls waiting for an R1 byte.
REQ-003 SHALL have parameter ACMD41_RETRY_MAX, default 1000: maximum CMD55+ACMD41 attempts.
REQ-004 MasterCLK  in  1  sole clock; all state changes on the rising edge.
REQ-005 Reset  in  1  synchronous, active-high reset.
REQ-006 Start  in  1  one-cycle request to begin initialization.
REQ-007 Busy  out  1  high from the cycle after an accepted Start until Done or Error.
REQ-008 Done  out  1  high when init succeeded; held until the next accepted Start.
REQ-009 Error  out  1  high when init failed; held until the next accepted Start.
REQ-010 ErrorCode  out  3  failure cause; valid while Error is high.
REQ-011 CardV2  out  1  card answered CMD8 validly; valid while Done is high.
REQ-012 SPI_CS  out  1  card select, active low.
REQ-013 ByteStart  out  1  one-cycle pulse requesting one SPI byte exchange.
REQ-014 ByteTx  out  8  byte to transmit; stable from ByteStart until ByteDone.
REQ-015 ByteRx  in  8  received byte; valid in the ByteDone cycle.
REQ-016 ByteDone  in  1  one-cycle pulse marking the end of an exchange.

Function
REQ-017 States SHALL be: IDLE, DUMMY, CMD, R1POLL, R7READ, GAP, DONE, ERR. A new ByteStart SHALL NOT be issued before ByteDone of the previous exchange.
REQ-018 IDLE --Start--> DUMMY. DUMMY sends DUMMY_BYTES bytes of 0xFF with SPI_CS=1, then goes to CMD for CMD0.
REQ-019 CMD SHALL drive SPI_CS=0 and send 6 bytes in this order: 0x40|index, arg[31:24], arg[23:16], arg[15:8], arg[7:0], crc.
REQ-020 The crc byte SHALL be 0x95 for CMD0, 0x87 for CMD8 and 0x01 otherwise.
REQ-021 R1POLL SHALL send 0xFF and finish on the first ByteRx with bit7=0. After R1_POLL_MAX polls without one, it SHALL go to ERR with code 3.
REQ-022 After each command, GAP SHALL drive SPI_CS=1 and send one 0xFF byte before the next state.
REQ-023 Sequence: CMD0 (arg 0) expecting R1=0x01, else ERR code 1. Then CMD8 (arg 0x000001AA) when SD_CMD8_EN is defined. Then the ACMD41 loop.
REQ-024 CMD8 with R1=0x05 (illegal command) SHALL set CardV2=0 and continue; no R7 bytes are read.
REQ-025 CMD8 with R1=0x01 SHALL read 4 R7 bytes in R7READ. Continue with CardV2=1 only if byte3[3:0]=0x1 and byte4=0xAA; otherwise ERR code 2. Any other CMD8 R1 value SHALL go to ERR code 2.
REQ-026 ACMD41 loop: send CMD55 (arg 0), any R1 with bit7=0 accepted. Then send CMD41 with arg 0x40000000 if CardV2, else 0x00000000.
REQ-027 If CMD41 returns R1=0x00, go to DONE. If it returns 0x01, retry. Any other value SHALL go to ERR code 4.
REQ-028 The retry counter SHALL count CMD41 attempts. When ACMD41_RETRY_MAX is reached with R1=0x01, go to ERR code 5. Counter width = clog2(ACMD41_RETRY_MAX+1), with no wrap.
REQ-029 DONE and ERR SHALL hold SPI_CS=1. Start in DONE or ERR clears Done, Error and ErrorCode and enters DUMMY. Start while Busy SHALL be ignored.
REQ-030 A ByteDone pulse outside an outstanding exchange SHALL be ignored.

Reset
REQ-031 Reset SHALL, in any state including mid-exchange, set: state=IDLE, SPI_CS=1, ByteStart=0, ByteTx=0xFF, Busy=0, Done=0, Error=0, ErrorCode=0, CardV2=0, and clear all counters.
REQ-032 Reset SHALL take priority over Start and ByteDone in the same cycle.

Configuration
REQ-033 With SD_CMD8_EN defined, the CMD8 step, R7READ and CardV2 detection SHALL be present.
REQ-034 With SD_CMD8_EN undefined, CMD0 SHALL be followed directly by the ACMD41 loop, CardV2 SHALL be tied to 0, ACMD41 arg SHALL be 0, and ErrorCode 2 is never produced.

Verification
REQ-035 Start, card model gives CMD0 R1=0x01, CMD8 R7 01 00 00 01 AA, ACMD41 R1 0x01 twice then 0x00 -> DONE, CardV2=1, 10 dummy bytes, CS high during dummies and gaps.
REQ-036 CMD0 R1=0x00 -> Error=1, ErrorCode=1, SPI_CS=1, no further ByteStart.
REQ-037 All polls return 0xFF after CMD0 -> ErrorCode=3 after exactly R1_POLL_MAX polls.
REQ-038 CMD8 R1=0x05 -> CardV2=0, CMD41 arg bytes 00 00 00 00, then DONE.
REQ-039 ACMD41 always 0x01 with ACMD41_RETRY_MAX=3 -> exactly 3 CMD41 frames, ErrorCode=5.
REQ-040 Reset asserted mid-CMD8 frame, then Start -> all outputs at reset values the next cycle, then a full sequence restarting from the dummy bytes.

Source files
------------

// File: rtl/sd_init_sequencer.sv
// sd_init_sequencer: SPI-mode SD card power-up initialisation.
// Drives a byte-exchange SPI engine through ByteStart/ByteDone: dummy clocks with CS high,
// CMD0, optional CMD8 + R7 check, then the CMD55/ACMD41 loop until the card leaves idle.
// Build option: define SD_CMD8_EN to include the CMD8 step, R7READ and CardV2 detection.
//
// state  | meaning
// IDLE   | after reset, waiting for Start
// DUMMY  | sending DUMMY_BYTES x 0xFF with CS high
// CMD    | sending the 6-byte command frame with CS low
// R1POLL | clocking 0xFF until an R1 byte (bit7 = 0) or poll limit
// R7READ | reading the 4 trailing R7 bytes of CMD8
// GAP    | one 0xFF with CS high between commands
// DONE   | card initialised, CS high, waiting for Start
// ERR    | init failed, CS high, waiting for Start
module sd_init_sequencer #(
    parameter int DUMMY_BYTES      = 10,
    parameter int R1_POLL_MAX      = 8,
    parameter int ACMD41_RETRY_MAX = 1000
) (
    input  logic       MasterCLK,
    input  logic       Reset,
    input  logic       Start,
    output logic       Busy,
    output logic       Done,
    output logic       Error,
    output logic [2:0] ErrorCode,
    output logic       CardV2,
    output logic       SPI_CS,
    output logic       ByteStart,
    output logic [7:0] ByteTx,
    input  logic [7:0] ByteRx,
    input  logic       ByteDone
);

    // The shared byte counter must cover dummy bytes, poll count and the 6-byte frame.
    localparam int CNT_A   = (DUMMY_BYTES > R1_POLL_MAX) ? DUMMY_BYTES : R1_POLL_MAX;
    localparam int CNT_MAX = (CNT_A > 6) ? CNT_A : 6;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int RW      = $clog2(ACMD41_RETRY_MAX + 1);

    typedef enum logic [2:0] {
        IDLE, DUMMY, CMD, R1POLL, R7READ, GAP, DONE, ERR
    } state_t;

    typedef enum logic [1:0] {
        CMD0, CMD8, CMD55, CMD41
    } cmd_t;

    state_t        state_q, state_d;
    cmd_t          cmd_q, cmd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] retry_q, retry_d;
    logic          pend_q, pend_d;
    logic          fin_q, fin_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          error_q, error_d;
    logic [2:0]    code_q, code_d;
    logic          cs_q, cs_d;
    logic          bstart_q, bstart_d;
    logic [7:0]    btx_q, btx_d;
`ifdef SD_CMD8_EN
    logic          cardv2_q, cardv2_d;
    logic          r7_ok_q, r7_ok_d;
`endif

    logic          xfer_done;
    logic [RW:0]   attempts;
    logic [5:0]    cmd_idx;
    logic [31:0]   cmd_arg;
    logic [7:0]    cmd_crc;
    logic [7:0]    tx_byte;

    // Byte to put on the wire for the current state/position; only CMD sends non-0xFF.
    always_comb begin
        cmd_idx = 6'd0;
        cmd_arg = 32'h0000_0000;
        cmd_crc = 8'h01;
        tx_byte = 8'hFF;
        case (cmd_q)
            CMD0: cmd_crc = 8'h95;
            CMD8: begin
                cmd_idx = 6'd8;
                cmd_arg = 32'h0000_01AA;
                cmd_crc = 8'h87;
            end
            CMD55: cmd_idx = 6'd55;
            CMD41: begin
                cmd_idx = 6'd41;
`ifdef SD_CMD8_EN
                cmd_arg = cardv2_q ? 32'h4000_0000 : 32'h0000_0000;
`endif
            end
            default: ;
        endcase
        if (state_q == CMD) begin
            case (cnt_q)
                CW'(0):  tx_byte = {2'b01, cmd_idx};
                CW'(1):  tx_byte = cmd_arg[31:24];
                CW'(2):  tx_byte = cmd_arg[23:16];
                CW'(3):  tx_byte = cmd_arg[15:8];
                CW'(4):  tx_byte = cmd_arg[7:0];
                CW'(5):  tx_byte = cmd_crc;
                default: tx_byte = 8'hFF;
            endcase
        end
    end

    // Sequencing: advance only on the ByteDone of our own outstanding exchange.
    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        cnt_d    = cnt_q;
        retry_d  = retry_q;
        pend_d   = pend_q;
        fin_d    = fin_q;
        busy_d   = busy_q;
        done_d   = done_q;
        error_d  = error_q;
        code_d   = code_q;
        bstart_d = 1'b0;
        btx_d    = btx_q;
`ifdef SD_CMD8_EN
        cardv2_d = cardv2_q;
        r7_ok_d  = r7_ok_q;
`endif
        xfer_done = pend_q & ByteDone;
        attempts  = {1'b0, retry_q} + (RW + 1)'(1);

        if (xfer_done) begin
            pend_d = 1'b0;
        end

        case (state_q)
            IDLE, DONE, ERR: begin
                if (Start) begin
                    state_d = DUMMY;
                    cmd_d   = CMD0;
                    cnt_d   = '0;
                    retry_d = '0;
                    pend_d  = 1'b0;
                    fin_d   = 1'b0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                    code_d  = 3'd0;
`ifdef SD_CMD8_EN
                    cardv2_d = 1'b0;
`endif
                end
            end
            DUMMY: begin
                if (xfer_done) begin
                    if (cnt_q == CW'(DUMMY_BYTES - 1)) begin
                        state_d = CMD;
                        cmd_d   = CMD0;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            CMD: begin
                if (xfer_done) begin
                    if (cnt_q == CW'(5)) begin
                        state_d = R1POLL;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            R1POLL: begin
                if (xfer_done) begin
                    if (!ByteRx[7]) begin
                        cnt_d = '0;
                        case (cmd_q)
                            CMD0: begin
                                if (ByteRx == 8'h01) begin
                                    state_d = GAP;
`ifdef SD_CMD8_EN
                                    cmd_d = CMD8;
`else
                                    cmd_d = CMD55;
`endif
                                end else begin
                                    state_d = ERR;
                                    error_d = 1'b1;
                                    busy_d  = 1'b0;
                                    code_d  = 3'd1;
                                end
                            end
`ifdef SD_CMD8_EN
                            CMD8: begin
                                if (ByteRx == 8'h05) begin
                                    cardv2_d = 1'b0;
                                    state_d  = GAP;
                                    cmd_d    = CMD55;
                                end else if (ByteRx == 8'h01) begin
                                    state_d = R7READ;
                                    r7_ok_d = 1'b1;
                                end else begin
                                    state_d = ERR;
                                    error_d = 1'b1;
                                    busy_d  = 1'b0;
                                    code_d  = 3'd2;
                                end
                            end
`endif
                            CMD55: begin
                                state_d = GAP;
                                cmd_d   = CMD41;
                            end
                            CMD41: begin
                                // Attempt counter saturates; it never wraps.
                                if (retry_q != RW'(ACMD41_RETRY_MAX)) begin
                                    retry_d = attempts[RW-1:0];
                                end
                                if (ByteRx == 8'h00) begin
                                    state_d = GAP;
                                    fin_d   = 1'b1;
                                end else if (ByteRx == 8'h01) begin
                                    if (attempts >= (RW + 1)'(ACMD41_RETRY_MAX)) begin
                                        state_d = ERR;
                                        error_d = 1'b1;
                                        busy_d  = 1'b0;
                                        code_d  = 3'd5;
                                    end else begin
                                        state_d = GAP;
                                        cmd_d   = CMD55;
                                    end
                                end else begin
                                    state_d = ERR;
                                    error_d = 1'b1;
                                    busy_d  = 1'b0;
                                    code_d  = 3'd4;
                                end
                            end
                            default: ;
                        endcase
                    end else if (cnt_q == CW'(R1_POLL_MAX - 1)) begin
                        state_d = ERR;
                        error_d = 1'b1;
                        busy_d  = 1'b0;
                        code_d  = 3'd3;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
`ifdef SD_CMD8_EN
            R7READ: begin
                if (xfer_done) begin
                    if (cnt_q == CW'(2) && ByteRx[3:0] != 4'h1) begin
                        r7_ok_d = 1'b0;
                    end
                    if (cnt_q == CW'(3)) begin
                        cnt_d = '0;
                        if (r7_ok_q && ByteRx == 8'hAA) begin
                            cardv2_d = 1'b1;
                            state_d  = GAP;
                            cmd_d    = CMD55;
                        end else begin
                            state_d = ERR;
                            error_d = 1'b1;
                            busy_d  = 1'b0;
                            code_d  = 3'd2;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
`endif
            GAP: begin
                if (xfer_done) begin
                    cnt_d = '0;
                    if (fin_q) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        fin_d   = 1'b0;
                    end else begin
                        state_d = CMD;
                    end
                end
            end
            default: ;
        endcase

        // One exchange at a time: a new byte is launched only once the previous one completed.
        if ((state_q == DUMMY || state_q == CMD || state_q == R1POLL ||
             state_q == R7READ || state_q == GAP) && !pend_q) begin
            bstart_d = 1'b1;
            btx_d    = tx_byte;
            pend_d   = 1'b1;
        end

        cs_d = !(state_d == CMD || state_d == R1POLL || state_d == R7READ);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge MasterCLK) begin
        if (Reset) begin
            state_q  <= IDLE;
            cmd_q    <= CMD0;
            cnt_q    <= '0;
            retry_q  <= '0;
            pend_q   <= 1'b0;
            fin_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            code_q   <= 3'd0;
            cs_q     <= 1'b1;
            bstart_q <= 1'b0;
            btx_q    <= 8'hFF;
`ifdef SD_CMD8_EN
            cardv2_q <= 1'b0;
            r7_ok_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            cnt_q    <= cnt_d;
            retry_q  <= retry_d;
            pend_q   <= pend_d;
            fin_q    <= fin_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            error_q  <= error_d;
            code_q   <= code_d;
            cs_q     <= cs_d;
            bstart_q <= bstart_d;
            btx_q    <= btx_d;
`ifdef SD_CMD8_EN
            cardv2_q <= cardv2_d;
            r7_ok_q  <= r7_ok_d;
`endif
        end
    end

    assign Busy      = busy_q;
    assign Done      = done_q;
    assign Error     = error_q;
    assign ErrorCode = code_q;
    assign SPI_CS    = cs_q;
    assign ByteStart = bstart_q;
    assign ByteTx    = btx_q;
`ifdef SD_CMD8_EN
    assign CardV2    = cardv2_q;
`else
    assign CardV2    = 1'b0;
`endif

endmodule

// File: tb/tb_sd_init_sequencer.sv
// Testbench for sd_init_sequencer: an SD card model answers the SPI byte stream, and a
// transcript model builds the expected {CS, byte} sequence and outcome for each scenario.
module tb_sd_init_sequencer;

    localparam int DUMMY_BYTES = 10;
    localparam int R1_POLL_MAX = 8;
    localparam int RETRY_MAX   = 3;
`ifdef SD_CMD8_EN
    localparam bit CMD8_EN = 1'b1;
`else
    localparam bit CMD8_EN = 1'b0;
`endif

    logic       MasterCLK = 1'b0;
    logic       Reset;
    logic       Start;
    logic       Busy, Done, Error, CardV2, SPI_CS, ByteStart, ByteDone;
    logic [2:0] ErrorCode;
    logic [7:0] ByteTx, ByteRx;

    int n_checks = 0;
    int n_errors = 0;

    // scenario description shared by the card and the transcript model
    logic [7:0]  sc_r1_cmd0, sc_r1_cmd8;
    logic [31:0] sc_r7;
    logic [7:0]  sc_r41 [0:7];
    bit          sc_silent0;
    int          sc_dly [0:15];

    // card state and observations
    logic [8:0] log_q [$];
    logic [7:0] resp_q [$];
    logic [7:0] fr [0:5];
    int         fr_n, frame_k, n41_seen, tx_unstable;

    // expected results
    logic [8:0] exp_q [$];
    bit         exp_done, exp_v2;
    logic [2:0] exp_code;
    int         exp_n41;

    sd_init_sequencer #(
        .DUMMY_BYTES     (DUMMY_BYTES),
        .R1_POLL_MAX     (R1_POLL_MAX),
        .ACMD41_RETRY_MAX(RETRY_MAX)
    ) dut (
        .MasterCLK(MasterCLK),
        .Reset    (Reset),
        .Start    (Start),
        .Busy     (Busy),
        .Done     (Done),
        .Error    (Error),
        .ErrorCode(ErrorCode),
        .CardV2   (CardV2),
        .SPI_CS   (SPI_CS),
        .ByteStart(ByteStart),
        .ByteTx   (ByteTx),
        .ByteRx   (ByteRx),
        .ByteDone (ByteDone)
    );

    initial forever #5 MasterCLK = ~MasterCLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // card reaction to a complete 6-byte command frame
    task automatic card_cmd();
        logic [5:0] idx;
        idx = fr[0][5:0];
        if (!(idx == 6'd0 && sc_silent0)) begin
            repeat (sc_dly[frame_k % 16]) resp_q.push_back(8'hFF);
            case (idx)
                6'd0:  resp_q.push_back(sc_r1_cmd0);
                6'd8: begin
                    resp_q.push_back(sc_r1_cmd8);
                    if (sc_r1_cmd8 == 8'h01) begin
                        resp_q.push_back(sc_r7[31:24]);
                        resp_q.push_back(sc_r7[23:16]);
                        resp_q.push_back(sc_r7[15:8]);
                        resp_q.push_back(sc_r7[7:0]);
                    end
                end
                6'd55: resp_q.push_back(8'h01);
                6'd41: begin
                    resp_q.push_back(sc_r41[n41_seen % 8]);
                    n41_seen++;
                end
                default: resp_q.push_back(8'h04);
            endcase
        end
        frame_k++;
    endtask

    // SD card: logs every exchange, answers after 1..3 cycles
    initial begin
        logic [7:0] tx, rsp;
        int d;
        ByteDone = 1'b0;
        ByteRx   = 8'hFF;
        forever begin
            @(negedge MasterCLK);
            if (ByteStart === 1'b1) begin
                tx = ByteTx;
                log_q.push_back({SPI_CS, tx});
                rsp = (resp_q.size() > 0) ? resp_q.pop_front() : 8'hFF;
                if (SPI_CS === 1'b0) begin
                    if (fr_n == 0) begin
                        if (tx[7:6] == 2'b01) begin
                            fr[0] = tx;
                            fr_n  = 1;
                        end
                    end else begin
                        fr[fr_n] = tx;
                        fr_n++;
                        if (fr_n == 6) begin
                            card_cmd();
                            fr_n = 0;
                        end
                    end
                end
                d = $urandom_range(1, 3);
                repeat (d) @(posedge MasterCLK);
                #1;
                if (ByteTx !== tx) tx_unstable++;
                ByteRx   = rsp;
                ByteDone = 1'b1;
                @(posedge MasterCLK);
                #1;
                ByteDone = 1'b0;
                ByteRx   = 8'($urandom);
            end
        end
    end

    task automatic card_clear();
        log_q.delete();
        resp_q.delete();
        fr_n        = 0;
        frame_k     = 0;
        n41_seen    = 0;
        tx_unstable = 0;
    endtask

    task automatic push_n(input logic cs, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back({cs, 8'hFF});
    endtask

    task automatic push_frame(input logic [5:0] idx, input logic [31:0] arg, input logic [7:0] crc);
        exp_q.push_back({1'b0, 2'b01, idx});
        exp_q.push_back({1'b0, arg[31:24]});
        exp_q.push_back({1'b0, arg[23:16]});
        exp_q.push_back({1'b0, arg[15:8]});
        exp_q.push_back({1'b0, arg[7:0]});
        exp_q.push_back({1'b0, crc});
    endtask

    // Expected transcript and outcome, written straight from the init procedure.
    task automatic build_exp();
        int fk;
        bit v2;
        logic [7:0] r;
        exp_q.delete();
        exp_done = 1'b0;
        exp_v2   = 1'b0;
        exp_code = 3'd0;
        exp_n41  = 0;
        fk = 0;
        v2 = 1'b0;
        push_n(1'b1, DUMMY_BYTES);
        push_frame(6'd0, 32'h0, 8'h95);
        if (sc_silent0) begin
            push_n(1'b0, R1_POLL_MAX);
            exp_code = 3'd3;
            return;
        end
        push_n(1'b0, sc_dly[fk] + 1);
        fk++;
        if (sc_r1_cmd0 != 8'h01) begin
            exp_code = 3'd1;
            return;
        end
        push_n(1'b1, 1);
        if (CMD8_EN) begin
            push_frame(6'd8, 32'h0000_01AA, 8'h87);
            push_n(1'b0, sc_dly[fk] + 1);
            fk++;
            if (sc_r1_cmd8 == 8'h05) begin
                push_n(1'b1, 1);
            end else if (sc_r1_cmd8 == 8'h01) begin
                push_n(1'b0, 4);
                if (sc_r7[11:8] == 4'h1 && sc_r7[7:0] == 8'hAA) begin
                    v2 = 1'b1;
                    push_n(1'b1, 1);
                end else begin
                    exp_code = 3'd2;
                    return;
                end
            end else begin
                exp_code = 3'd2;
                return;
            end
        end
        for (int k = 0; k < RETRY_MAX; k++) begin
            push_frame(6'd55, 32'h0, 8'h01);
            push_n(1'b0, sc_dly[fk] + 1);
            fk++;
            push_n(1'b1, 1);
            push_frame(6'd41, v2 ? 32'h4000_0000 : 32'h0, 8'h01);
            push_n(1'b0, sc_dly[fk] + 1);
            fk++;
            exp_n41++;
            r = sc_r41[k];
            if (r == 8'h00) begin
                push_n(1'b1, 1);
                exp_done = 1'b1;
                exp_v2   = v2;
                return;
            end else if (r == 8'h01) begin
                if (k + 1 >= RETRY_MAX) begin
                    exp_code = 3'd5;
                    return;
                end
                push_n(1'b1, 1);
            end else begin
                exp_code = 3'd4;
                return;
            end
        end
    endtask

    task automatic set_scn(input logic [7:0] r1_0, input logic [7:0] r1_8, input logic [31:0] r7,
                           input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] a2,
                           input bit silent);
        sc_r1_cmd0 = r1_0;
        sc_r1_cmd8 = r1_8;
        sc_r7      = r7;
        sc_silent0 = silent;
        for (int i = 0; i < 8; i++) sc_r41[i] = 8'h01;
        sc_r41[0] = a0;
        sc_r41[1] = a1;
        sc_r41[2] = a2;
        for (int i = 0; i < 16; i++) sc_dly[i] = $urandom_range(0, R1_POLL_MAX - 1);
    endtask

    task automatic run_scn(input string nm, input bit extra_start);
        bit seen;
        int e0;
        card_clear();
        build_exp();
        @(posedge MasterCLK); #1 Start = 1'b1;
        @(posedge MasterCLK); #1 Start = 1'b0;
        chk({nm, ".busy_on"}, 32'(Busy), 32'd1);
        chk({nm, ".cleared"}, 32'({Done, Error, ErrorCode}), 32'd0);
        if (extra_start) begin
            repeat (5) @(posedge MasterCLK);
            #1 Start = 1'b1;
            @(posedge MasterCLK); #1 Start = 1'b0;
        end
        seen = 1'b0;
        for (int c = 0; c < 6000 && !seen; c++) begin
            @(negedge MasterCLK);
            if (Done || Error) seen = 1'b1;
        end
        chk({nm, ".timeout"}, 32'(seen), 32'd1);
        chk({nm, ".done"}, 32'(Done), 32'(exp_done));
        chk({nm, ".error"}, 32'(Error), 32'(!exp_done));
        chk({nm, ".code"}, 32'(ErrorCode), 32'(exp_code));
        chk({nm, ".cs_idle"}, 32'(SPI_CS), 32'd1);
        chk({nm, ".busy_off"}, 32'(Busy), 32'd0);
        if (exp_done) chk({nm, ".cardv2"}, 32'(CardV2), 32'(exp_v2));
        repeat (30) @(negedge MasterCLK);
        chk({nm, ".len"}, 32'(log_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            e0 = n_errors;
            chk($sformatf("%s.byte%0d", nm, i), 32'(log_q[i]), 32'(exp_q[i]));
            if (n_errors != e0) break;
        end
        chk({nm, ".n_cmd41"}, 32'(n41_seen), 32'(exp_n41));
        chk({nm, ".tx_stable"}, 32'(tx_unstable), 32'd0);
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, ".cs"}, 32'(SPI_CS), 32'd1);
        chk({nm, ".bstart"}, 32'(ByteStart), 32'd0);
        chk({nm, ".btx"}, 32'(ByteTx), 32'hFF);
        chk({nm, ".flags"}, 32'({Busy, Done, Error, CardV2}), 32'd0);
        chk({nm, ".code"}, 32'(ErrorCode), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] r41v [0:2];
        int target;
        bit reached;
        Reset = 1'b1;
        Start = 1'b0;
        card_clear();
        repeat (3) @(posedge MasterCLK);
        #1;
        chk_reset_vals("reset");
        Reset = 1'b0;

        set_scn(8'h01, 8'h01, 32'h0000_01AA, 8'h01, 8'h01, 8'h00, 1'b0);
        run_scn("basic", 1'b1);
        set_scn(8'h00, 8'h01, 32'h0000_01AA, 8'h00, 8'h00, 8'h00, 1'b0);
        run_scn("cmd0_bad", 1'b0);
        set_scn(8'h01, 8'h01, 32'h0000_01AA, 8'h00, 8'h00, 8'h00, 1'b1);
        run_scn("no_r1", 1'b0);
        set_scn(8'h01, 8'h05, 32'h0000_01AA, 8'h00, 8'h00, 8'h00, 1'b0);
        run_scn("v1_card", 1'b0);
        set_scn(8'h01, 8'h01, 32'h0000_01AA, 8'h01, 8'h01, 8'h01, 1'b0);
        run_scn("retry_max", 1'b0);
        set_scn(8'h01, 8'h01, 32'h0000_01AA, 8'h01, 8'h04, 8'h00, 1'b0);
        run_scn("acmd41_bad", 1'b0);
        set_scn(8'h01, 8'h01, 32'h0000_02AA, 8'h00, 8'h00, 8'h00, 1'b0);
        run_scn("r7_bad", 1'b0);
        set_scn(8'h01, 8'h03, 32'h0000_01AA, 8'h00, 8'h00, 8'h00, 1'b0);
        run_scn("cmd8_bad", 1'b0);

        // reset in the middle of the second command frame, with Start in the same cycle
        card_clear();
        set_scn(8'h01, 8'h01, 32'h0000_01AA, 8'h01, 8'h01, 8'h00, 1'b0);
        @(posedge MasterCLK); #1 Start = 1'b1;
        @(posedge MasterCLK); #1 Start = 1'b0;
        target  = DUMMY_BYTES + 6 + sc_dly[0] + 1 + 1 + 2;
        reached = 1'b0;
        for (int c = 0; c < 3000 && !reached; c++) begin
            @(negedge MasterCLK);
            if (log_q.size() >= target) reached = 1'b1;
        end
        chk("midrst.reach", 32'(reached), 32'd1);
        @(posedge MasterCLK); #1 Reset = 1'b1; Start = 1'b1;
        @(posedge MasterCLK); #1 Reset = 1'b0; Start = 1'b0;
        chk_reset_vals("midrst");
        repeat (10) @(posedge MasterCLK);
        #1;
        chk("midrst.idle_busy", 32'(Busy), 32'd0);
        run_scn("after_rst", 1'b0);

        for (int s = 0; s < 8; s++) begin
            for (int k = 0; k < 3; k++) begin
                case ($urandom_range(0, 3))
                    0:       r41v[k] = 8'h00;
                    3:       r41v[k] = 8'h04;
                    default: r41v[k] = 8'h01;
                endcase
            end
            set_scn(($urandom_range(0, 5) == 0) ? 8'h00 : 8'h01,
                    ($urandom_range(0, 3) == 0) ? 8'h05 : (($urandom_range(0, 5) == 0) ? 8'h03 : 8'h01),
                    ($urandom_range(0, 3) == 0) ? 32'h0000_0155 : 32'h0000_01AA,
                    r41v[0], r41v[1], r41v[2],
                    $urandom_range(0, 9) == 0);
            run_scn($sformatf("rnd%0d", s), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
